// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg: shared FSM states, error counter width and march expected-word helper
package ram_bist_pkg;
    typedef enum logic [2:0] {IDLE, W0, R0, W1, R1, DONE} state_t;
    localparam int ERR_CNT_W = 8;
    function automatic logic [63:0] exp_word(input logic [63:0] bg, input logic [63:0] a, input logic inv);
        return inv ? ~(bg ^ a) : (bg ^ a);
    endfunction
endpackage

// File: rtl/ram_bist_mux.sv
// ram_bist_mux: combinational RAM port select between system and BIST sources
module ram_bist_mux #(
    parameter int WIDTH = 8,
    parameter int AW = 1
) (
    input  logic             sel,
    input  logic [AW-1:0]    sys_addr,
    input  logic [WIDTH-1:0] sys_d,
    input  logic             sys_we,
    input  logic [AW-1:0]    bist_addr,
    input  logic [WIDTH-1:0] bist_d,
    input  logic             bist_we,
    output logic [AW-1:0]    ram_addr,
    output logic [WIDTH-1:0] ram_d,
    output logic             ram_we
);
    assign ram_addr = sel ? bist_addr : sys_addr;
    assign ram_d    = sel ? bist_d : sys_d;
    assign ram_we   = sel ? bist_we : sys_we;
endmodule

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: march BIST FSM, comparator and RAM access mux; RAM_BIST_ERRLOG_EN adds first-fail capture
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int AW = 1,
    parameter logic [WIDTH-1:0] BG = 8'h55
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [AW-1:0]        sys_addr,
    input  logic [WIDTH-1:0]     sys_d,
    input  logic                 sys_we,
    output logic [WIDTH-1:0]     sys_q,
    output logic [AW-1:0]        ram_addr,
    output logic [WIDTH-1:0]     ram_d,
    output logic                 ram_we,
    input  logic [WIDTH-1:0]     ram_q,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] err_count
`ifdef RAM_BIST_ERRLOG_EN
    ,
    output logic [AW-1:0]        first_fail_addr,
    output logic [WIDTH-1:0]     first_fail_data
`endif
);
    state_t state, state_nxt;
    logic [AW-1:0] addr_cnt;
    logic [WIDTH-1:0] e;
    logic last, miss, go;
    assign busy = state inside {W0, R0, W1, R1};
    assign done = state == DONE;
    assign pass = done && err_count == '0;
    assign sys_q = ram_q;
    assign go = !busy && start;
    assign last = addr_cnt == AW'(DEPTH - 1);
    assign e = WIDTH'(exp_word(64'(BG), 64'(addr_cnt), state inside {W1, R1}));
    assign miss = (state inside {R0, R1}) && ram_q != e;
    // enum order makes state+1 the next march phase, R1+1 landing on DONE
    always_comb begin
        state_nxt = busy ? (last ? state_t'(state + 3'd1) : state) : (go ? W0 : state);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr_cnt  <= '0;
            err_count <= '0;
        end else begin
            state     <= state_nxt;
            addr_cnt  <= busy && !last ? addr_cnt + 1'b1 : '0;
            err_count <= go ? '0 : (miss && err_count != '1) ? err_count + 1'b1 : err_count;
        end
    end
`ifdef RAM_BIST_ERRLOG_EN
    always_ff @(posedge clk) begin
        if (rst || go) begin
            first_fail_addr <= '0;
            first_fail_data <= '0;
        end else if (miss && err_count == '0) begin
            first_fail_addr <= addr_cnt;
            first_fail_data <= ram_q;
        end
    end
`endif
    ram_bist_mux #(.WIDTH(WIDTH), .AW(AW)) u_mux (
        .sel       (busy),
        .sys_addr  (sys_addr),
        .sys_d     (sys_d),
        .sys_we    (sys_we),
        .bist_addr (addr_cnt),
        .bist_d    (e),
        .bist_we   (state inside {W0, W1}),
        .ram_addr  (ram_addr),
        .ram_d     (ram_d),
        .ram_we    (ram_we)
    );
endmodule

// File: doc/ram_bist_ctrl.md
# ram_bist_ctrl

Built-in self-test front-end and access mux placed directly upstream of the DFFRAM macro (`RAM2x8` and its larger siblings). In normal operation it forwards the system port to the RAM combinationally. On `start` it takes over the RAM and runs a four-phase write/read-compare march over every address. It reports `done`, `pass` and a saturating error count.

## Interface
- `WIDTH`, 8: RAM word width.
- `DEPTH`, 2: number of RAM words.
- `AW`, 1: address width, equal to max(1, clog2(DEPTH)).
- `BG`, 8'h55: data background; `WIDTH` bits wide.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: level-sampled; starts a test when in IDLE or DONE.
- `sys_addr` in AW: system address.
- `sys_d` in WIDTH: system write data.
- `sys_we` in 1: system write enable.
- `sys_q` out WIDTH: system read data; always equal to `ram_q`.
- `ram_addr` out AW: to RAM `addr`.
- `ram_d` out WIDTH: to RAM `D`.
- `ram_we` out 1: to RAM `we`.
- `ram_q` in WIDTH: from RAM `Q`; combinational from `ram_addr`.
- `busy` out 1: high in W0/R0/W1/R1.
- `done` out 1: high in DONE.
- `pass` out 1: `done` and `err_count` == 0.
- `err_count` out 8: miscompare count; saturates at 255.

## Operation
- States: IDLE, W0, R0, W1, R1, DONE.
- IDLE, start=1 → W0 with `addr_cnt`=0. DONE, start=1 → W0 with `err_count` cleared.
- In W0/R0/W1/R1, `addr_cnt` increments every cycle.
- At `addr_cnt`=DEPTH-1 the FSM advances (W0→R0→W1→R1→DONE) and `addr_cnt` wraps to 0.
- Expected word: E(a) = BG ^ zero-extended a.
- W0 drives `ram_we`=1, `ram_d`=E(a). W1 drives `ram_we`=1, `ram_d`=~E(a).
- R0 drives `ram_we`=0 and compares `ram_q` to E(a) at the edge ending the cycle. R1 does the same against ~E(a).
- Any miscompare increments `err_count`, saturating at 255.
- Mux while busy: `ram_addr`=`addr_cnt`; `sys_we` is dropped; `sys_addr` and `sys_d` are ignored.
- Mux in IDLE/DONE: `ram_addr`=`sys_addr`, `ram_d`=`sys_d`, `ram_we`=`sys_we`, combinationally.
- `start` is ignored while busy.
- Reset values: state IDLE, `addr_cnt` 0, `busy`/`done`/`pass` 0, `err_count` 0.
- Reset mid-test: IDLE on the next edge, counters cleared, mux returns to the system port that cycle. RAM contents are undefined.

## Timing
- Start sampled at edge k; W0 occupies the cycle after edge k.
- Test cycles end at edges k+1 … k+4·DEPTH; `done`/`pass` are valid after edge k+4·DEPTH.
- For DEPTH=2, `done` rises 8 edges after the start edge.
- `busy` rises after edge k and falls after edge k+4·DEPTH.
- No added latency on the system path in IDLE/DONE. System read data is combinational through `ram_q`.
- `err_count` reflects a miscompare at the edge closing that read cycle.

## Configuration
- `RAM_BIST_ERRLOG_EN` defined: adds outputs `first_fail_addr` (AW) and `first_fail_data` (WIDTH).
  - Both capture `addr_cnt` and `ram_q` on the first miscompare of a run and then hold.
  - Reset and start clear them to 0.
- Macro undefined: those ports and registers do not exist; all other behaviour is identical.

## Structure
- Shared package `ram_bist_pkg` holds:
  - the state enum (IDLE, W0, R0, W1, R1, DONE);
  - the `ERR_CNT_W`=8 constant;
  - the expected-word function E(a) and its phase inversion.
- One sub-module: `ram_bist_mux`, the purely combinational system/BIST port select.
- The FSM, counters and comparator live in `ram_bist_ctrl`.

## Test plan
All scenarios use a DUT connected to a `RAM2x8` model, DEPTH=2.
- Reset then system access:
  - After reset: `busy`=0, `done`=0, `pass`=0, `err_count`=0.
  - System write 0x3C to addr 1, then read addr 1 → `sys_q`=0x3C.
- Clean run:
  - One-cycle `start` → RAM written 0x55, 0x54, read back, then written 0xAA, 0xAB and read back.
  - `done`=1 exactly 8 edges after the start edge, `pass`=1, `err_count`=0.
  - RAM finally holds 0xAA, 0xAB.
- Stuck-at-0 fault:
  - Bench forces `ram_q[0]`=0 → miscompares at R0 addr 0 and R1 addr 1; `err_count`=2, `pass`=0.
  - With the macro: `first_fail_addr`=0, `first_fail_data`=0x54.
- Interference during a run:
  - `sys_we`=1 with `sys_d`=0xFF every cycle, and `start` held high → no 0xFF reaches the RAM.
  - Run still finishes in 8 edges with `pass`=1.
  - Because `start` is still high in DONE, the test restarts on the next edge.
- Reset mid-run:
  - `rst` at the 3rd test cycle → next cycle `busy`=0, `err_count`=0, `ram_we` follows `sys_we`.
  - A fresh `start` then completes with `pass`=1.
- Restart from DONE:
  - After the fault run (`err_count`=2), remove the fault and pulse `start` → `err_count` clears.
  - New run completes with `pass`=1.
